// File: rtl/reg_file_wb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reg_file_wb_pkg
// Shared sizes and writeback command encodings for the writeback stage.
// Revision : 1.0
// ----------------------------------------------------------------------------
package reg_file_wb_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [1:0] wb_cmd_t;

  localparam wb_cmd_t WB_CMD_SEL = 2'b00;
  localparam wb_cmd_t WB_CMD_LUI = 2'b01;
  localparam wb_cmd_t WB_CMD_LB  = 2'b10;
  localparam wb_cmd_t WB_CMD_LH  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/reg_file_wb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reg_file_wb_if
// Writeback bundle, decode read ports and last-commit record.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface reg_file_wb_if;
  import reg_file_wb_pkg::*;

  logic                 we_reg;
  logic                 mux9;
  logic [XLEN-1:0]      result;
  logic [XLEN-1:0]      mem;
  logic [REG_IDX_W-1:0] rd;
  wb_cmd_t              cmd;
  logic [19:0]          imm20;
  logic                 flush;
  logic                 stall;
  logic [REG_IDX_W-1:0] ra1;
  logic [REG_IDX_W-1:0] ra2;
  logic [XLEN-1:0]      rd1;
  logic [XLEN-1:0]      rd2;
  logic [XLEN-1:0]      wb_data;
  logic                 last_valid;
  logic [REG_IDX_W-1:0] last_rd;
  logic [XLEN-1:0]      last_data;

  modport master (
    output we_reg, mux9, result, mem, rd, cmd, imm20, flush, stall, ra1, ra2,
    input  rd1, rd2, wb_data, last_valid, last_rd, last_data
  );

  modport slave (
    input  we_reg, mux9, result, mem, rd, cmd, imm20, flush, stall, ra1, ra2,
    output rd1, rd2, wb_data, last_valid, last_rd, last_data
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_wb_wb_format.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : wb_format
// Pure combinational formatter producing the final writeback value.
// Revision : 1.0
// ----------------------------------------------------------------------------
module wb_format
  import reg_file_wb_pkg::*;
(
  input  wire wb_cmd_t         cmd_i,
  input  wire logic            mux9_i,
  input  wire logic [XLEN-1:0] result_i,
  input  wire logic [XLEN-1:0] mem_i,
  input  wire logic [19:0]     imm20_i,
  output logic      [XLEN-1:0] wb_data_o
);

  always_comb begin
    wb_data_o = result_i;
    case (cmd_i)
      WB_CMD_SEL: wb_data_o = mux9_i ? mem_i : result_i;
      WB_CMD_LUI: wb_data_o = {imm20_i, 12'b0};
      WB_CMD_LB:  wb_data_o = {{(XLEN-8){mem_i[7]}}, mem_i[7:0]};
      WB_CMD_LH:  wb_data_o = {{(XLEN-16){mem_i[15]}}, mem_i[15:0]};
      default:    wb_data_o = result_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reg_file_wb
// Writeback commit into a 32x32 register file with bypassed reads and a
// registered record of the last commit.
// Revision : 1.0
// ----------------------------------------------------------------------------
module reg_file_wb
  import reg_file_wb_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst,
  reg_file_wb_if.slave  bus
);

  logic [XLEN-1:0]      regs_q [NREG];
  logic                 last_valid_q;
  logic [REG_IDX_W-1:0] last_rd_q;
  logic [XLEN-1:0]      last_data_q;

  logic [XLEN-1:0]      wb_data_d;
  logic                 commit_d;
  logic [XLEN-1:0]      rd1_d;
  logic [XLEN-1:0]      rd2_d;

  wb_format u_wb_format (
    .cmd_i     (bus.cmd),
    .mux9_i    (bus.mux9),
    .result_i  (bus.result),
    .mem_i     (bus.mem),
    .imm20_i   (bus.imm20),
    .wb_data_o (wb_data_d)
  );

  assign commit_d = bus.we_reg & ~bus.flush & ~bus.stall & (bus.rd != '0);

  // regs_q[0] is cleared on reset and never written, so x0 storage stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      last_valid_q <= 1'b0;
      last_rd_q    <= '0;
      last_data_q  <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (commit_d && (bus.rd == REG_IDX_W'(i))) begin
          regs_q[i] <= wb_data_d;
        end
      end
      last_valid_q <= commit_d;
      if (commit_d) begin
        last_rd_q   <= bus.rd;
        last_data_q <= wb_data_d;
      end
    end
  end

  always_comb begin
    rd1_d = regs_q[bus.ra1];
    if (bus.ra1 == '0) begin
      rd1_d = '0;
    end else if (commit_d && (bus.ra1 == bus.rd)) begin
      rd1_d = wb_data_d;
    end
  end

  always_comb begin
    rd2_d = regs_q[bus.ra2];
    if (bus.ra2 == '0) begin
      rd2_d = '0;
    end else if (commit_d && (bus.ra2 == bus.rd)) begin
      rd2_d = wb_data_d;
    end
  end

  assign bus.rd1        = rd1_d;
  assign bus.rd2        = rd2_d;
  assign bus.wb_data    = wb_data_d;
  assign bus.last_valid = last_valid_q;
  assign bus.last_rd    = last_rd_q;
  assign bus.last_data  = last_data_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_reg_file_wb
// Directed self-checking bench for reg_file_wb.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_reg_file_wb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reg_file_wb_if bus ();

  reg_file_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.we_reg = 1'b0; bus.mux9 = 1'b0; bus.result = '0; bus.mem = '0;
    bus.rd = '0; bus.cmd = 2'b00; bus.imm20 = '0; bus.flush = 1'b0;
    bus.stall = 1'b0;
  endtask

  // One committed writeback; leaves we_reg low just after the edge.
  task automatic wr(input logic [4:0] idx, input logic [1:0] cmd, input logic m9,
                    input logic [31:0] res, input logic [31:0] mem,
                    input logic [19:0] imm);
    @(negedge clk);
    bus.we_reg = 1'b1; bus.rd = idx; bus.cmd = cmd; bus.mux9 = m9;
    bus.result = res; bus.mem = mem; bus.imm20 = imm;
    @(posedge clk); #1;
    bus.we_reg = 1'b0;
  endtask

  initial begin
    idle();
    bus.ra1 = 5'd5; bus.ra2 = 5'd31;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset_rd1", bus.rd1, 32'h0);
    check("reset_rd2", bus.rd2, 32'h0);
    check("reset_last_valid", {31'b0, bus.last_valid}, 32'h0);

    // Basic write with same-cycle bypass
    @(negedge clk);
    bus.we_reg = 1'b1; bus.rd = 5'd3; bus.cmd = 2'b00; bus.mux9 = 1'b0;
    bus.result = 32'h1234_5678; bus.mem = 32'hDEAD_BEEF; bus.ra1 = 5'd3;
    #1;
    check("bypass_rd1", bus.rd1, 32'h1234_5678);
    check("bypass_wb_data", bus.wb_data, 32'h1234_5678);
    @(posedge clk); #1;
    bus.we_reg = 1'b0;
    #1;
    check("stored_rd1", bus.rd1, 32'h1234_5678);
    check("last_valid_after_write", {31'b0, bus.last_valid}, 32'h1);
    check("last_rd_after_write", {27'b0, bus.last_rd}, 32'd3);
    check("last_data_after_write", bus.last_data, 32'h1234_5678);
    @(posedge clk); #1;
    check("last_valid_drops", {31'b0, bus.last_valid}, 32'h0);
    check("last_rd_holds_idle", {27'b0, bus.last_rd}, 32'd3);

    // Formatting
    wr(5'd8, 2'b00, 1'b1, 32'h0000_0001, 32'hCAFE_BABE, 20'h0);
    wr(5'd4, 2'b01, 1'b1, 32'h0000_0001, 32'h0000_0002, 20'hABCDE);
    wr(5'd5, 2'b10, 1'b0, 32'h0000_0003, 32'h0000_0080, 20'h0);
    wr(5'd6, 2'b11, 1'b1, 32'h0000_0004, 32'h0000_7FFF, 20'h0);
    wr(5'd10, 2'b11, 1'b0, 32'h0000_0005, 32'h1234_8001, 20'h0);
    wr(5'd11, 2'b10, 1'b1, 32'h0000_0006, 32'h0000_017F, 20'h0);
    bus.ra1 = 5'd4; bus.ra2 = 5'd5; #1;
    check("x4_lui", bus.rd1, 32'hABCD_E000);
    check("x5_lb_neg", bus.rd2, 32'hFFFF_FF80);
    bus.ra1 = 5'd6; bus.ra2 = 5'd8; #1;
    check("x6_lh_pos", bus.rd1, 32'h0000_7FFF);
    check("x8_sel_mem", bus.rd2, 32'hCAFE_BABE);
    bus.ra1 = 5'd10; bus.ra2 = 5'd11; #1;
    check("x10_lh_neg", bus.rd1, 32'hFFFF_8001);
    check("x11_lb_pos", bus.rd2, 32'h0000_007F);
    bus.ra1 = 5'd3; #1;
    check("x3_untouched", bus.rd1, 32'h1234_5678);

    // Both ports bypass the same register
    @(negedge clk);
    bus.we_reg = 1'b1; bus.rd = 5'd12; bus.cmd = 2'b00; bus.mux9 = 1'b0;
    bus.result = 32'hA5A5_0F0F; bus.ra1 = 5'd12; bus.ra2 = 5'd12;
    #1;
    check("dual_bypass_rd1", bus.rd1, 32'hA5A5_0F0F);
    check("dual_bypass_rd2", bus.rd2, 32'hA5A5_0F0F);
    @(posedge clk); #1;
    bus.we_reg = 1'b0;

    // x0 protection
    @(negedge clk);
    bus.we_reg = 1'b1; bus.rd = 5'd0; bus.cmd = 2'b00; bus.mux9 = 1'b0;
    bus.result = 32'hFFFF_FFFF; bus.ra1 = 5'd0; bus.ra2 = 5'd0;
    #1;
    check("x0_same_rd1", bus.rd1, 32'h0);
    check("x0_same_rd2", bus.rd2, 32'h0);
    @(posedge clk); #1;
    bus.we_reg = 1'b0;
    #1;
    check("x0_next_rd1", bus.rd1, 32'h0);
    check("x0_next_rd2", bus.rd2, 32'h0);
    check("x0_last_valid", {31'b0, bus.last_valid}, 32'h0);
    check("x0_last_rd_holds", {27'b0, bus.last_rd}, 32'd12);

    // Stall, then flush+stall, then flush alone
    wr(5'd7, 2'b00, 1'b0, 32'h0000_0011, 32'h0, 20'h0);
    @(negedge clk);
    bus.we_reg = 1'b1; bus.rd = 5'd7; bus.result = 32'h22; bus.stall = 1'b1;
    bus.ra1 = 5'd7;
    #1;
    check("stall_no_bypass", bus.rd1, 32'h11);
    @(posedge clk); #1;
    check("stall_x7", bus.rd1, 32'h11);
    check("stall_last_valid", {31'b0, bus.last_valid}, 32'h0);
    check("stall_last_rd", {27'b0, bus.last_rd}, 32'd7);
    check("stall_last_data", bus.last_data, 32'h11);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    check("flushstall_x7", bus.rd1, 32'h11);
    check("flushstall_last_valid", {31'b0, bus.last_valid}, 32'h0);
    check("flushstall_last_data", bus.last_data, 32'h11);
    bus.stall = 1'b0;
    #1;
    check("flush_no_bypass", bus.rd1, 32'h11);
    @(posedge clk); #1;
    check("flush_x7", bus.rd1, 32'h11);
    check("flush_last_rd", {27'b0, bus.last_rd}, 32'd7);
    idle();

    // Asynchronous reset between edges
    wr(5'd9, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 20'h0);
    bus.ra1 = 5'd9; bus.ra2 = 5'd3; #1;
    check("x9_before_reset", bus.rd1, 32'h55);
    check("last_rd_before_reset", {27'b0, bus.last_rd}, 32'd9);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_x9", bus.rd1, 32'h0);
    check("async_x3", bus.rd2, 32'h0);
    check("async_last_valid", {31'b0, bus.last_valid}, 32'h0);
    check("async_last_rd", {27'b0, bus.last_rd}, 32'd0);
    check("async_last_data", bus.last_data, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_x9", bus.rd1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Writeback-side consumer of the memory/writeback pipeline register.
- Takes the registered writeback bundle: write enable, destination, ALU result, memory data, select, command and 20-bit immediate.
- Forms the final writeback value and commits it into a 32x32 integer register file.
- Serves two combinational read ports to decode, with write-through bypass, and keeps a one-entry registered record of the last commit for the hazard/forwarding unit.

Parameters:
- XLEN, 32, data width of result, memory data and registers.
- NREG, 32, number of architectural registers; register index width is log2(NREG) = 5.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- we_reg  in  1  writeback enable from the pipeline register.
- mux9  in  1  source select for cmd 00: 0 = result, 1 = mem.
- result  in  XLEN  ALU result.
- mem  in  XLEN  load data.
- rd  in  5  destination register index.
- cmd  in  2  writeback format (see Behaviour).
- imm20  in  20  upper immediate.
- flush  in  1  squash the current writeback.
- stall  in  1  hold; no commit this cycle.
- ra1  in  5  read address, port 1.
- ra2  in  5  read address, port 2.
- rd1  out  XLEN  read data, port 1.
- rd2  out  XLEN  read data, port 2.
- wb_data  out  XLEN  combinational formatted writeback value.
- last_valid  out  1  registered: a commit happened last cycle.
- last_rd  out  5  registered index of that commit.
- last_data  out  XLEN  registered data of that commit.

Behaviour:
- Commit condition: commit = we_reg & ~flush & ~stall & (rd != 0).
- Writeback formatting, combinational, drives wb_data:
  - cmd 00: mux9 ? mem : result.
  - cmd 01: {imm20, 12'b0} (upper-immediate load).
  - cmd 10: sign-extend mem[7:0] to XLEN.
  - cmd 11: sign-extend mem[15:0] to XLEN.
  - mux9 is ignored for cmd != 00.
- Register write:
  - On the rising edge with commit = 1, regs[rd] <= wb_data.
  - No other register changes on that edge.
- x0:
  - Register 0 always reads 0.
  - A write with rd = 0 is dropped, and last_valid stays 0 for it.
- Read ports:
  - Combinational, zero latency.
  - rdN = 0 if raN = 0.
  - Else rdN = wb_data if commit & (raN == rd).
  - Else rdN = regs[raN].
  - Both ports may hit the same register, and both may bypass in the same cycle.
- Last-commit record, updated every rising edge:
  - last_valid <= commit.
  - last_rd <= commit ? rd : last_rd.
  - last_data <= commit ? wb_data : last_data.
- flush has priority over stall. With both high: no commit, and last_valid <= 0.
- stall alone: no commit, last_valid <= 0, last_rd/last_data hold.
- Reset (asynchronous, any time, including mid-operation):
  - All regs[1..NREG-1], last_valid, last_rd and last_data clear to 0 immediately.
  - While rst is asserted, rd1 and rd2 read 0 for every address except through the bypass path. The bypass path is allowed, since commit logic still evaluates.
  - A write coincident with the edge on which rst deasserts is not guaranteed.
- Latency: a committed value is visible via bypass in the same cycle and from storage in the next cycle.

Decomposition:
- Shared package holds:
  - WB_CMD_SEL = 2'b00, WB_CMD_LUI = 2'b01, WB_CMD_LB = 2'b10, WB_CMD_LH = 2'b11.
  - XLEN, REG_IDX_W = 5, NREG.
- One natural sub-module: wb_format, the pure combinational cmd/mux9/imm20 to wb_data formatter, reused by the forwarding unit.
- Storage and bypass stay in reg_file_wb.

Test Plan:
- Reset then read:
  - Stimulus: assert rst, release; ra1 = 5, ra2 = 31.
  - Response: rd1 = rd2 = 0, last_valid = 0.
- Basic write and bypass:
  - Stimulus: we_reg = 1, rd = 3, cmd = 00, mux9 = 0, result = 0x1234_5678, ra1 = 3.
  - Response: rd1 = 0x1234_5678 in the same cycle. Next cycle, with we_reg = 0: rd1 = 0x1234_5678, last_valid = 1, last_rd = 3.
- Formatting:
  - Stimulus: cmd = 01, imm20 = 0xABCDE, rd = 4. Then cmd = 10, mem = 0x0000_0080, rd = 5. Then cmd = 11, mem = 0x0000_7FFF, rd = 6.
  - Response: x4 = 0xABCD_E000, x5 = 0xFFFF_FF80, x6 = 0x0000_7FFF.
- x0 protection:
  - Stimulus: we_reg = 1, rd = 0, result = 0xFFFF_FFFF; ra1 = ra2 = 0.
  - Response: rd1 = rd2 = 0 in both the same and the next cycle; last_valid = 0.
- Flush/stall priority:
  - Stimulus: x7 = 0x11 previously. Write rd = 7, result = 0x22 with stall = 1, then with flush = 1 and stall = 1.
  - Response: x7 stays 0x11 after both cycles; last_valid = 0; last_rd and last_data hold their previous values.
- Asynchronous reset mid-run:
  - Stimulus: x9 = 0x55. Assert rst between clock edges.
  - Response: x9 reads 0 before the next rising edge; last_valid/last_rd/last_data = 0.
